osu_sc_cell_vector_sequencer: RTL
=================================

// Module: osu_sc_cell_vector_sequencer
// PURPOSE
//   On-chip exhaustive test sequencer for one combinational standard cell
//   (default: 2-input NAND). Drives every input vector onto the cell under
//   test, waits a settle window, samples the cell output, compares it against
//   a parameterised truth table and reports pass/fail, mismatch count and the
//   first failing vector. Sits in the library test-chip harness, one per DUT.
// PARAMETERS
//   N_IN    2        number of DUT inputs; vectors 0 .. 2**N_IN-1
//   TRUTH   4'b0111  expected output; bit i = expected Y for VEC==i (NAND2)
//   SETTLE  2        cycles each vector is held (>=1); Y sampled at hold end
//   ERR_W   8        width of saturating mismatch counter
// PORTS
//   CLK        in   1       clock, all state updates on rising edge
//   RN         in   1       reset, synchronous, active-low
//   START      in   1       pulse: begin a run (accepted in IDLE or DONE)
//   ABORT      in   1       stop current run, return to IDLE
//   Y          in   1       DUT output (synchronous to CLK)
//   VEC        out  N_IN    DUT input vector, VEC[0] -> first cell input
//   BUSY       out  1       run in progress
//   DONE       out  1       run completed; held until next START/ABORT
//   PASS       out  1       valid with DONE: 1 iff ERR_CNT==0
//   ERR_CNT    out  ERR_W   mismatches this run, saturates at all-ones
//   FAIL_VALID out  1       at least one mismatch captured this run
//   FAIL_VEC   out  N_IN    first mismatching vector (valid when FAIL_VALID)
// BEHAVIOUR
//   - Reset (RN==0 at an edge): state IDLE; VEC=0, BUSY=0, DONE=0, PASS=0,
//     ERR_CNT=0, FAIL_VALID=0, FAIL_VEC=0. Applies mid-run with no other effect.
//   - FSM states IDLE, RUN, DONE:
//     IDLE/DONE + START (ABORT low) -> RUN; same edge: VEC=0, hold cnt=SETTLE-1,
//       ERR_CNT=0, FAIL_VALID=0, FAIL_VEC=0, DONE=0, PASS=0, BUSY=1.
//     RUN: each vector held exactly SETTLE cycles. On the edge where cnt==0:
//       compare Y vs TRUTH[VEC]; on mismatch ERR_CNT+=1 (saturating) and, if
//       FAIL_VALID==0, FAIL_VEC=VEC, FAIL_VALID=1. Then if VEC==2**N_IN-1
//       -> DONE (BUSY=0, DONE=1, PASS=final ERR_CNT==0, VEC=0); else VEC+=1,
//       cnt=SETTLE-1. Otherwise cnt-=1.
//     RUN + ABORT -> IDLE next edge: BUSY=0, DONE=0, PASS=0, VEC=0; ERR_CNT,
//       FAIL_VALID, FAIL_VEC keep values (partial result, no sample that edge).
//     DONE + ABORT -> IDLE, DONE=0, PASS=0, counters retained.
//   - Latency: BUSY high exactly 2**N_IN*SETTLE cycles; DONE rises on the
//     edge after the last sample edge's cycle, i.e. same edge as BUSY falls.
//   - START while BUSY ignored (run not restarted). START with ABORT same
//     edge: ABORT wins. START in DONE restarts and clears results.
//   - VEC changes only on sample edges/start/exit; glitch-free, registered.
//   - Y is not synchronised internally; harness provides synchronous Y.
//   - PASS is 0 whenever DONE is 0.
// TESTING (defaults unless stated: NAND2, SETTLE=2, 8 BUSY cycles)
//   1 Ideal NAND2 model on Y, START pulse -> VEC 0,0,1,1,2,2,3,3; BUSY 8 cyc;
//     DONE=1, PASS=1, ERR_CNT=0, FAIL_VALID=0.
//   2 Y stuck-at-1 -> ERR_CNT=1, FAIL_VEC=2'b11, FAIL_VALID=1, PASS=0.
//   3 Y stuck-at-0 -> ERR_CNT=3, FAIL_VEC=2'b00; then START again with ideal
//     model -> results cleared, PASS=1.
//   4 ABORT on 3rd BUSY cycle with Y stuck-0 -> IDLE next edge, DONE=0,
//     VEC=0, ERR_CNT=1 retained; START pulses mid-run ignored (BUSY 8 cyc).
//   5 RN low for one edge mid-run -> all outputs reset values next edge;
//     START+ABORT together in IDLE -> stays IDLE.
//   6 ERR_W=1, Y stuck-0 -> ERR_CNT saturates at 1; N_IN=3, TRUTH=8'h7F
//     (NAND3), SETTLE=1 -> BUSY 8 cycles, PASS=1 with ideal NAND3.

Source files
------------

// File: rtl/osu_sc_cell_vector_sequencer.sv
// Exhaustive vector sequencer for one combinational standard cell under test.
// Walks every input vector, samples Y at the end of each hold window and scores it against TRUTH.
module osu_sc_cell_vector_sequencer #(
    parameter int                  N_IN   = 2,
    parameter logic [2**N_IN-1:0]  TRUTH  = 4'b0111,
    parameter int                  SETTLE = 2,
    parameter int                  ERR_W  = 8
) (
    input  logic             clk_i,
    input  logic             rn_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             y_i,
    output logic [N_IN-1:0]  vec_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic             fail_valid_o,
    output logic [N_IN-1:0]  fail_vec_o
);

    // state  | meaning
    // S_IDLE | waiting for START, last partial/complete results retained
    // S_RUN  | driving vectors, sampling Y when the hold counter reaches zero
    // S_DONE | run complete, PASS valid until next START or ABORT

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fv_q, fv_d;
    logic [N_IN-1:0]  fvec_q, fvec_d;

    always_ff @(posedge clk_i) begin
        if (!rn_i) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fvec_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fvec_q  <= fvec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fvec_d  = fvec_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (start_i) begin
                    state_d = S_RUN;
                    vec_d   = '0;
                    cnt_d   = CNT_LOAD;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    fvec_d  = '0;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    // Partial score is kept so the harness can read it back.
                    state_d = S_IDLE;
                    vec_d   = '0;
                end else if (cnt_q == '0) begin
                    if (y_i != TRUTH[vec_q]) begin
                        if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
                        if (!fv_q) begin
                            fv_d   = 1'b1;
                            fvec_d = vec_q;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        state_d = S_DONE;
                        vec_d   = '0;
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                        cnt_d = CNT_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign vec_o        = vec_q;
    assign busy_o       = (state_q == S_RUN);
    assign done_o       = (state_q == S_DONE);
    assign pass_o       = (state_q == S_DONE) && (err_q == '0);
    assign err_cnt_o    = err_q;
    assign fail_valid_o = fv_q;
    assign fail_vec_o   = fvec_q;

endmodule
